// File: rtl/matmul_seq_if.sv
// Start/status handshake and single-port RAM bus for the sequential matrix multiplier.
// The master side belongs to matmul_seq; the slave side belongs to whatever drives Start and owns the RAM.
interface matmul_seq_if;
  logic        Start;
  logic        Busy;
  logic        Done;
  logic        MemEnable;
  logic        MemReadWrite;
  logic [7:0]  MemAddr;
  logic [15:0] MemWData;
  logic [15:0] MemRData;

  modport master (
    input  Start, MemRData,
    output Busy, Done, MemEnable, MemReadWrite, MemAddr, MemWData
  );

  modport slave (
    output Start, MemRData,
    input  Busy, Done, MemEnable, MemReadWrite, MemAddr, MemWData
  );
endinterface

// File: rtl/matmul_seq.sv
// Sequential C = A x B over a shared single-port RAM: one multiply-accumulate
// per three cycles (read A, read B, MAC), then one write per C element.
module matmul_seq #(
  parameter int N      = 4,
  parameter int A_BASE = 0,
  parameter int B_BASE = 16,
  parameter int C_BASE = 32
) (
  input  logic          Clock,
  input  logic          Reset,
  matmul_seq_if.master  bus
);
  localparam int DATA_W = 16;
  localparam int IW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR, DONE} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DATA_W-1:0]   acc_q, acc_d, areg_q, areg_d;

  // Unsigned multiply-accumulate wrapping modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] mac_wrap(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
    return DATA_W'(acc + x * y);
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      areg_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      areg_q  <= areg_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    i_d              = i_q;
    j_d              = j_q;
    k_d              = k_q;
    acc_d            = acc_q;
    areg_d           = areg_q;
    bus.Busy         = 1'b0;
    bus.Done         = 1'b0;
    bus.MemEnable    = 1'b0;
    bus.MemReadWrite = 1'b1;
    bus.MemAddr      = '0;
    bus.MemWData     = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = RD_A;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      RD_A: begin
        bus.Busy      = 1'b1;
        bus.MemEnable = 1'b1;
        bus.MemAddr   = 8'(A_BASE + int'(i_q) * N + int'(k_q));
        state_d       = RD_B;
      end
      // A word from the previous cycle's read is on MemRData now.
      RD_B: begin
        bus.Busy      = 1'b1;
        bus.MemEnable = 1'b1;
        bus.MemAddr   = 8'(B_BASE + int'(k_q) * N + int'(j_q));
        areg_d        = bus.MemRData;
        state_d       = MAC;
      end
      MAC: begin
        bus.Busy = 1'b1;
        acc_d    = mac_wrap(acc_q, areg_q, bus.MemRData);
        if (k_q == LAST) begin
          state_d = WR;
        end else begin
          k_d     = k_q + IW'(1);
          state_d = RD_A;
        end
      end
      WR: begin
        bus.Busy         = 1'b1;
        bus.MemEnable    = 1'b1;
        bus.MemReadWrite = 1'b0;
        bus.MemAddr      = 8'(C_BASE + int'(i_q) * N + int'(j_q));
        bus.MemWData     = acc_q;
        k_d              = '0;
        acc_d            = '0;
        if (j_q != LAST) begin
          j_d     = j_q + IW'(1);
          state_d = RD_A;
        end else if (i_q != LAST) begin
          j_d     = '0;
          i_d     = i_q + IW'(1);
          state_d = RD_A;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.Done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq: RAM model, table of operand/result vectors, write scoreboard
// and hand sequences for Start-while-busy, mid-run reset and Start held through DONE.
module tb_matmul_seq;
  localparam int N  = 4;
  localparam int AB = 0;
  localparam int BB = 16;
  localparam int CB = 32;

  typedef struct {
    logic [15:0] a [16];
    logic [15:0] b [16];
    logic [15:0] c [16];
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matmul_seq_if bus ();

  matmul_seq #(.N(N), .A_BASE(AB), .B_BASE(BB), .C_BASE(CB)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.master)
  );

  logic [15:0] mem [256];
  logic [15:0] img [256];
  bit          load_req = 1'b0;

  // Single-port RAM, one-cycle read latency; load_req copies a prepared image in.
  always @(posedge clk) begin
    if (load_req) mem <= img;
    else if (bus.MemEnable) begin
      if (bus.MemReadWrite) bus.MemRData <= mem[bus.MemAddr];
      else mem[bus.MemAddr] <= bus.MemWData;
    end
  end

  int   total = 0;
  int   bad = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  wr_t  sb [$];
  wr_t  mon_e;
  vec_t vt [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic bit in_ab(input logic [7:0] a);
    return (int'(a) >= AB && int'(a) < AB + 16) || (int'(a) >= BB && int'(a) < BB + 16);
  endfunction

  function automatic bit in_c(input logic [7:0] a);
    return int'(a) >= CB && int'(a) < CB + 16;
  endfunction

  // Bus monitor: region check on every access, scoreboard check on every write.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.Done) done_cnt++;
      if (bus.MemEnable) begin
        if (bus.MemReadWrite) chk("rd_region", 32'(in_ab(bus.MemAddr)), 1);
        else begin
          wr_cnt++;
          chk("wr_region", 32'(in_c(bus.MemAddr)), 1);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected_write got=%0h want=none", bus.MemAddr);
          end else begin
            mon_e = sb.pop_front();
            chk("wr_addr", 32'(bus.MemAddr), 32'(mon_e.addr));
            chk("wr_data", 32'(bus.MemWData), 32'(mon_e.data));
          end
        end
      end
    end
  end

  task automatic load_vec(input int v);
    for (int x = 0; x < 256; x++) img[x] = 16'hBEEF;
    for (int x = 0; x < 16; x++) begin
      img[AB + x] = vt[v].a[x];
      img[BB + x] = vt[v].b[x];
    end
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  // mode: 0 plain, 1 Start re-pulsed at cycle 40, 2 reset at cycle 50, 3 Start raised before DONE
  task automatic run(input int v, input int mode, output int done_n);
    int gaps;
    wr_t e;
    load_vec(v);
    sb.delete();
    for (int x = 0; x < 16; x++) begin
      e.addr = 8'(CB + x);
      e.data = vt[v].c[x];
      sb.push_back(e);
    end
    wr_cnt = 0;
    done_cnt = 0;
    gaps = 0;
    done_n = -1;
    @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    for (int n = 0; n < 260; n++) begin
      if (bus.Done) begin
        done_n = n;
        break;
      end
      if (!bus.Busy) gaps++;
      if (mode == 1) bus.Start = (n == 39);
      if (mode == 2 && n == 49) begin
        rst = 1'b1;
        break;
      end
      if (mode == 3 && n == 207) bus.Start = 1'b1;
      @(negedge clk);
    end
    chk("busy_gap", gaps, 0);
  endtask

  task automatic finish_run(input int v, input int dn);
    chk("done_latency", dn, 208);
    @(negedge clk);
    chk("post_done", 32'(bus.Done), 0);
    chk("post_busy", 32'(bus.Busy), 0);
    chk("done_count", done_cnt, 1);
    chk("write_count", wr_cnt, 16);
    chk("sb_left", sb.size(), 0);
    for (int x = 0; x < 16; x++) chk($sformatf("c_mem%0d", x), 32'(mem[CB + x]), 32'(vt[v].c[x]));
  endtask

  initial begin
    int dn;
    logic [15:0] s;
    bus.Start = 1'b0;

    // Table: identity, 16-bit wrap, all-ones A, random with reference product.
    for (int x = 0; x < 16; x++) begin
      vt[0].a[x] = (x / 4 == x % 4) ? 16'd1 : 16'd0;
      vt[0].b[x] = 16'(x + 1);
      vt[0].c[x] = 16'(x + 1);
      vt[1].a[x] = (x == 0) ? 16'hFFFF : 16'h0000;
      vt[1].b[x] = (x == 0) ? 16'h0002 : 16'h0000;
      vt[1].c[x] = (x == 0) ? 16'hFFFE : 16'h0000;
      vt[2].a[x] = 16'd1;
      vt[2].b[x] = 16'(x);
      vt[2].c[x] = 16'(24 + 4 * (x % 4));
      vt[3].a[x] = 16'($urandom);
      vt[3].b[x] = 16'($urandom);
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = '0;
        for (int k = 0; k < 4; k++) s = s + 16'(vt[3].a[r*4+k] * vt[3].b[k*4+c]);
        vt[3].c[r*4+c] = s;
      end

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_en", 32'(bus.MemEnable), 0);
    chk("rst_rw", 32'(bus.MemReadWrite), 1);
    chk("rst_addr", 32'(bus.MemAddr), 0);
    chk("rst_wdata", 32'(bus.MemWData), 0);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      run(v, 0, dn);
      finish_run(v, dn);
    end

    run(0, 1, dn);
    finish_run(0, dn);

    // Reset at cycle 50: three elements already written, nothing else afterwards.
    run(2, 2, dn);
    @(negedge clk);
    chk("abort_en", 32'(bus.MemEnable), 0);
    chk("abort_busy", 32'(bus.Busy), 0);
    chk("abort_done", 32'(bus.Done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_writes", wr_cnt, 3);
    chk("abort_sb_left", sb.size(), 13);
    for (int x = 0; x < 3; x++) chk($sformatf("abort_c%0d", x), 32'(mem[CB + x]), 32'(vt[2].c[x]));
    chk("abort_c3_unwritten", 32'(mem[CB + 3]), 32'hBEEF);
    run(2, 0, dn);
    finish_run(2, dn);

    // Start held high through DONE: IDLE for one cycle, then a new run begins.
    run(1, 3, dn);
    chk("hold_done_latency", dn, 208);
    @(negedge clk);
    chk("hold_idle_busy", 32'(bus.Busy), 0);
    chk("hold_idle_en", 32'(bus.MemEnable), 0);
    @(negedge clk);
    chk("hold_restart_busy", 32'(bus.Busy), 1);
    chk("hold_restart_en", 32'(bus.MemEnable), 1);
    chk("hold_restart_addr", 32'(bus.MemAddr), AB);
    rst = 1'b1;
    bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("hold_writes", wr_cnt, 16);
    chk("hold_done_cnt", done_cnt, 1);
    chk("hold_c0", 32'(mem[CB]), 32'hFFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- N, 4, matrix dimension (N x N operands and result)
- A_BASE, 0, RAM word address of A[0][0], row-major
- B_BASE, 16, RAM word address of B[0][0], row-major
- C_BASE, 32, RAM word address of C[0][0], row-major
REQ-002 The block SHALL have one clock; reset is synchronous and active-high, with ports named Clock and Reset.
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- Clock, in, 1, rising-edge clock shared with the RAM
- Reset, in, 1, synchronous active-high reset
- Start, in, 1, request one C = A x B computation
- Busy, out, 1, high while a computation is in progress
- Done, out, 1, one-cycle completion pulse
- MemEnable, out, 1, drives the RAM Enable input
- MemReadWrite, out, 1, drives the RAM ReadWrite input (1 = read, 0 = write)
- MemAddr, out, 8, RAM word address
- MemWData, out, 16, drives the RAM DataIn input
- MemRData, in, 16, driven by the RAM DataOut output

Function
REQ-004 The block SHALL implement the states IDLE, RD_A, RD_B, MAC, WR and DONE.
REQ-005 In IDLE, sampling Start=1 at a rising edge SHALL move the block to RD_A and clear i, j, k and Acc; Start=0 SHALL leave the block in IDLE.
REQ-006 In RD_A, the block SHALL drive MemEnable=1, MemReadWrite=1, MemAddr=A_BASE+i*N+k, and SHALL then go to RD_B.
REQ-007 In RD_B, the block SHALL drive MemEnable=1, MemReadWrite=1, MemAddr=B_BASE+k*N+j, SHALL capture MemRData into register Areg, and SHALL then go to MAC.
- RAM read latency is one cycle: data is valid the cycle after the read is issued.
REQ-008 In MAC, the block SHALL drive MemEnable=0 and update Acc <= Acc + Areg*MemRData.
- The arithmetic is unsigned; the 32-bit product is truncated and Acc keeps the low 16 bits (wraps mod 2^16).
- If k==N-1, the next state SHALL be WR; otherwise k SHALL increment and the next state SHALL be RD_A.
REQ-009 In WR, the block SHALL drive MemEnable=1, MemReadWrite=0, MemAddr=C_BASE+i*N+j and MemWData=Acc, and SHALL then clear k and Acc.
- If j<N-1: j increments, next state RD_A.
- Else if i<N-1: j=0, i increments, next state RD_A.
- Else: next state DONE.
REQ-010 DONE SHALL last exactly one cycle, with Done=1 and Busy=0, and SHALL then return to IDLE.
REQ-011 Busy SHALL be 1 in RD_A, RD_B, MAC and WR, and 0 in IDLE and DONE.
REQ-012 Start SHALL be ignored in every state except IDLE; a Start held high through DONE SHALL begin a new run from IDLE on the following edge.
REQ-013 When not in RD_A, RD_B or WR, the outputs SHALL be MemEnable=0, MemReadWrite=1, MemAddr=0 and MemWData=0.
REQ-014 Each C element SHALL take 3N+1 cycles, so a full run SHALL take N*N*(3N+1) cycles plus 1 DONE cycle; for N=4, Done is high in the 209th cycle after the Start-accept edge.
REQ-015 The block SHALL NOT write any RAM address other than C_BASE..C_BASE+N*N-1, and SHALL NOT write the A or B regions.
REQ-016 Parameter constraint: every A, B and C address SHALL fit in 8 bits, and the A, B and C regions SHALL not overlap; otherwise behaviour is undefined.

Reset
REQ-017 Reset=1 at a rising edge SHALL force, on that edge:
- state=IDLE; i=j=k=0; Acc=0; Areg=0
- Busy=0, Done=0, MemEnable=0, MemReadWrite=1, MemAddr=0, MemWData=0
REQ-018 Reset SHALL take priority over Start and over every state transition.
REQ-019 Reset asserted mid-run SHALL abort the run:
- no further RAM access and no Done pulse
- C elements already written stay in RAM; the remaining elements are not written

Verification
REQ-020 Identity: A=I (N=4), B[r][c]=r*4+c+1, Start pulsed once -> C region holds 1..16 in row-major order, Done pulses once, exactly 16 write cycles occur.
REQ-021 Latency: after the run in REQ-020, Done=1 exactly 208 edges after the Start-accept edge, and Busy is continuously high for 208 cycles before it.
REQ-022 Wrap: A[0][0]=0xFFFF, B[0][0]=0x0002, all other A and B words 0 -> C[0][0]=0xFFFE and every other C word is 0x0000.
REQ-023 Start ignored: Start pulsed again at cycle 40 of a run -> no restart, total run length unchanged, exactly one Done pulse.
REQ-024 Reset mid-run: Reset at cycle 50 -> next cycle MemEnable=0, Busy=0 and no Done pulse; a fresh Start then yields the correct C.
REQ-025 Address check: monitor every MemEnable=1 cycle -> reads fall only in the A/B regions and writes fall only in C_BASE..C_BASE+15.
